// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words into a ccff configuration chain and returns the bits shifted out as readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 28,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] buf_q, pack;
  logic buf_full, shift, last_bit, word_end, pack_end;
  logic [IW-1:0] bit_idx, pack_idx;
  // a pending readback word blocks shifting so the packer never overruns
  always_comb begin
    shift = state == SHIFT && buf_full && bit_count < CNT_W'(CHAIN_LEN) && !(rb_valid && !rb_ready);
    last_bit = bit_count == CNT_W'(CHAIN_LEN - 1);
    word_end = bit_idx == IW'(DATA_W - 1);
    pack_end = pack_idx == IW'(DATA_W - 1);
    ccff_en = shift;
    ccff_head = shift && buf_q[bit_idx];
    s_ready = state == SHIFT && !buf_full;
    busy = state != IDLE;
    state_nx = state == IDLE  ? (start && !done ? SHIFT : IDLE) :
               state == SHIFT ? (shift && last_bit ? DRAIN : SHIFT) :
               (rb_valid && rb_ready ? IDLE : DRAIN);
  end
  always_ff @(posedge prog_clk)
    if (pReset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      buf_q <= '0;
      buf_full <= 1'b0;
      bit_idx <= '0;
      pack <= '0;
      pack_idx <= '0;
      rb_data <= '0;
      rb_valid <= 1'b0;
      done <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= state == DRAIN && rb_valid && rb_ready;
      if (state == IDLE && start && !done) bit_count <= '0;
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      if (s_valid && s_ready) begin
        buf_q <= s_data;
        buf_full <= 1'b1;
        bit_idx <= '0;
      end
      if (shift) begin
        bit_count <= bit_count + 1'b1;
        bit_idx <= bit_idx + 1'b1;
        if (word_end || last_bit) buf_full <= 1'b0;
        if (pack_end || last_bit) begin
          rb_data <= pack | (DATA_W'(ccff_tail) << pack_idx);
          rb_valid <= 1'b1;
          pack <= '0;
          pack_idx <= '0;
        end else begin
          pack[pack_idx] <= ccff_tail;
          pack_idx <= pack_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed loads against chain models for a 28-bit and a 16-bit chain.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  logic pReset, start, s_valid, s_ready, ccff_head, ccff_en, ccff_tail, rb_valid, rb_ready, busy, done;
  logic [7:0] s_data, rb_data;
  logic [15:0] bit_count;
  logic start2, sv2, sr2, head2, en2, tail2, rbv2, busy2, done2;
  logic [7:0] sd2, rbd2;
  logic [15:0] bc2;
  logic [27:0] ch = '0;
  logic [15:0] ch2 = '0;
  int n_chk = 0, n_bad = 0;
  int acc, en_cnt, rbn, late_ready, unstable, stall_en, rate_bad;
  logic [31:0] hv, rbv;
  always #5 clk = ~clk;
  ccff_chain_loader dut (
    .prog_clk(clk), .pReset(pReset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready), .busy(busy), .done(done),
    .bit_count(bit_count)
  );
  ccff_chain_loader #(.CHAIN_LEN(16), .DATA_W(8), .CNT_W(16)) dut16 (
    .prog_clk(clk), .pReset(pReset), .start(start2), .s_data(sd2), .s_valid(sv2),
    .s_ready(sr2), .ccff_head(head2), .ccff_en(en2), .ccff_tail(tail2),
    .rb_data(rbd2), .rb_valid(rbv2), .rb_ready(1'b1), .busy(busy2), .done(done2),
    .bit_count(bc2)
  );
  // chain models: head enters bit 0, tail is the far end
  always @(posedge clk) begin
    if (ccff_en) ch <= {ch[26:0], ccff_head};
    if (en2) ch2 <= {ch2[14:0], head2};
  end
  assign ccff_tail = ch[27];
  assign tail2 = ch2[15];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_load(input logic [31:0] words, input bit gaps, input bit stall, input bit hold_start, input int rst_at);
    int cyc = 0, stall_left = 0, en_since = 0;
    bit stalled = 0, prev_hold = 0, fin = 0;
    logic [7:0] prev_rb = '0;
    acc = 0; en_cnt = 0; rbn = 0; late_ready = 0; unstable = 0; stall_en = 0; rate_bad = 0;
    hv = '0; rbv = '0;
    while (!fin && cyc < 400) begin
      start = cyc == 0 || (hold_start && cyc >= 5);
      s_valid = acc < 4 && (!gaps || $urandom_range(0, 2) != 0);
      s_data = acc < 4 ? words[acc*8 +: 8] : 8'h00;
      rb_ready = stall_left == 0;
      if (stall_left > 0) stall_left--;
      pReset = rst_at > 0 && en_cnt == rst_at;
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_on", busy, 1);
        chk("cnt_clr", bit_count, 0);
      end
      if (prev_hold && (rb_data !== prev_rb || !rb_valid)) unstable++;
      prev_hold = rb_valid && !rb_ready;
      prev_rb = rb_data;
      if (rb_valid && rb_ready) begin
        if (rbn < 4) rbv[rbn*8 +: 8] = rb_data;
        rbn++;
        en_since = 0;
      end
      if (ccff_en) begin
        if (en_cnt < 32) hv[en_cnt] = ccff_head;
        en_cnt++;
        en_since++;
        if (rb_valid && !rb_ready) stall_en++;
      end
      if (en_since > 8) rate_bad++;
      if (s_ready && acc >= 4) late_ready++;
      if (s_valid && s_ready) acc++;
      if (stall && !stalled && rb_valid) begin
        stalled = 1;
        stall_left = 5;
      end
      if (done || pReset) fin = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 0; s_valid = 0; rb_ready = 1; pReset = 0;
    if (!fin) chk("timeout", cyc, 0);
  endtask
  task automatic post(input logic [31:0] exp_hv, input logic [31:0] exp_rb, input bit use_rb);
    chk("en_cnt", en_cnt, 28);
    chk("accepts", acc, 4);
    chk("rb_words", rbn, 4);
    chk("head_bits", hv, exp_hv);
    if (use_rb) chk("rb_data", rbv, exp_rb);
    chk("late_ready", late_ready, 0);
    chk("rb_stable", unstable, 0);
    chk("stall_en", stall_en, 0);
    chk("rb_rate", rate_bad, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_off", busy, 0);
    chk("bit_count", bit_count, 28);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cyc, acc2, en2_cnt, late2, rbn2, rb_cyc, done_cyc;
    bit fin2;
    logic [31:0] hv2;
    pReset = 1; start = 0; s_valid = 0; s_data = 0; rb_ready = 1;
    start2 = 0; sv2 = 0; sd2 = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_sready", s_ready, 0);
    chk("rst_en", ccff_en, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_rbv", rb_valid, 0);
    chk("rst_rbd", rb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", bit_count, 0);
    @(posedge clk);
    #1;
    pReset = 0;
    run_load(32'h09F03CA5, 0, 0, 0, 0);
    post(32'h09F03CA5, 32'h00000000, 1);
    run_load(32'h0F563412, 0, 0, 0, 0);
    post(32'h0F563412, 32'h09F03CA5, 1);
    run_load(32'h060FC35A, 1, 1, 0, 0);
    post(32'h060FC35A, 32'h0F563412, 1);
    // start held from mid-shift through the done cycle must not relaunch
    run_load(32'h44332211, 0, 0, 1, 0);
    post(32'h04332211, 32'h060FC35A, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_cnt", bit_count, 28);
    @(posedge clk);
    #1;
    run_load(32'h88776655, 0, 0, 0, 10);
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", ccff_en, 0);
    chk("mid_rst_rbv", rb_valid, 0);
    chk("mid_rst_cnt", bit_count, 0);
    @(posedge clk);
    #1;
    run_load(32'hDDCCBBAA, 0, 0, 0, 0);
    post(32'h0DCCBBAA, 32'h0, 0);
    cyc = 0; acc2 = 0; en2_cnt = 0; late2 = 0; rbn2 = 0; rb_cyc = -10; done_cyc = 0; fin2 = 0; hv2 = '0;
    while (!fin2 && cyc < 200) begin
      start2 = cyc == 0;
      sv2 = 1;
      sd2 = acc2 == 0 ? 8'h81 : acc2 == 1 ? 8'h7E : 8'h55;
      @(negedge clk);
      if (en2) begin
        if (en2_cnt < 32) hv2[en2_cnt] = head2;
        en2_cnt++;
      end
      if (sr2 && acc2 >= 2) late2++;
      if (sv2 && sr2) acc2++;
      if (rbv2) begin
        rbn2++;
        rb_cyc = cyc;
      end
      if (done2) begin
        done_cyc = cyc;
        fin2 = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    sv2 = 0;
    start2 = 0;
    if (!fin2) chk("timeout16", cyc, 0);
    chk("acc16", acc2, 2);
    chk("late16", late2, 0);
    chk("en16", en2_cnt, 16);
    chk("head16", hv2, 32'h00007E81);
    chk("rb16", rbn2, 2);
    chk("done16", done_cyc, rb_cyc + 1);
    chk("cnt16", bc2, 16);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration controller that serially loads a switch-block configuration chain through its ccff_head/ccff_tail ports.
- Accepts bitstream words over a valid/ready stream, serializes them onto ccff_head, and drives a per-bit chain-advance enable.
- Captures the bits shifted out of ccff_tail and returns them as readback words, so the previous chain contents can be verified.
- Sits between the bitstream source and one tile's configuration chain (e.g. 14 two-bit mux memories = 28 bits).

Parameters:
- CHAIN_LEN, 28, total configuration bits in the chain (must be >= 1).
- DATA_W, 8, width of the bitstream and readback words.
- CNT_W, 16, width of bit_count (must satisfy 2^CNT_W > CHAIN_LEN).

Ports:
- prog_clk  in  1  programming clock; every flop updates on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- s_data  in  DATA_W  bitstream word; LSB is shifted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  word is accepted when s_valid and s_ready are both high.
- ccff_head  out  1  serial data into the chain.
- ccff_en  out  1  chain advance enable; chain flops shift only on edges where ccff_en=1.
- ccff_tail  in  1  serial data out of the chain.
- rb_data  out  DATA_W  readback word, LSB = first bit out of the chain.
- rb_valid  out  1  rb_data is valid.
- rb_ready  in  1  consumer accepts rb_data.
- busy  out  1  high in SHIFT and DRAIN.
- done  out  1  one-cycle pulse at the end of a load.
- bit_count  out  CNT_W  number of bits shifted in the current or most recent load.

Behaviour:
- Clock/reset: single clock domain, prog_clk. pReset is synchronous and active-high.
- Reset values: state=IDLE; s_ready, ccff_head, ccff_en, rb_valid, busy, done = 0; rb_data = 0; bit_count = 0; word buffer empty; readback packer empty.
- FSM IDLE:
  - start=1 -> SHIFT.
  - On that transition, bit_count is cleared and busy=1 from the next cycle.
- FSM SHIFT:
  - s_ready = word buffer empty.
  - On an accepted word, the buffer loads s_data with a per-word bit index of 0. No bit shifts in the accept cycle, so each word costs one bubble cycle.
  - A shift cycle happens when the buffer is full, bit_count < CHAIN_LEN, and NOT (rb_valid && !rb_ready).
  - In a shift cycle:
    - ccff_en = 1.
    - ccff_head = buffer[bit index], combinational from the registered buffer.
    - ccff_tail is sampled into the packer at the current bit position.
    - bit_count and the bit index increment.
  - ccff_en = 0 in every other cycle; ccff_head is then held at 0.
  - The buffer empties after its DATA_W-th bit, or immediately once bit_count reaches CHAIN_LEN. Bits of the final word beyond CHAIN_LEN are discarded.
  - Packer: when DATA_W bits are collected, or the CHAIN_LEN-th bit is captured, rb_data/rb_valid are registered on the next edge. Unused upper bits are 0.
  - When the CHAIN_LEN-th bit has shifted -> DRAIN.
- FSM DRAIN:
  - Stays until the final readback word has been accepted (rb_valid && rb_ready).
  - Then done=1 for exactly one cycle and the FSM returns to IDLE.
  - s_ready = 0 throughout DRAIN.
- Readback hold: rb_valid stays high with rb_data stable until rb_ready.
- Readback stall: while rb_valid && !rb_ready, shifting stops. No bit may be lost or duplicated.
- Readback rate: in SHIFT, ccff_en may assert at most DATA_W times between rb handshakes.
- start handling:
  - Ignored while busy.
  - A start in the same cycle as done is ignored; start is honoured from the IDLE cycle after done.
- Reset mid-operation: pReset wins over all events. The next cycle shows reset values; partial words and readback words are discarded, and chain contents are undefined until a full reload.
- Counts: ccff_en is high for exactly CHAIN_LEN cycles per load, and exactly ceil(CHAIN_LEN/DATA_W) words are accepted and returned.

Test Plan:
- Basic load (CHAIN_LEN=28, DATA_W=8, rb_ready=1): start, then words 0xA5,0x3C,0xF0,0x09 with no gaps -> ccff_en high for exactly 28 cycles; head bits equal the LSB-first stream with the 0x09 upper nibble ignored; s_ready low after the 4th accept; done pulses once; bit_count=28.
- Readback: chain model preloaded with 28 bits equal to words 0x12,0x34,0x56,0x0F -> four rb words returned 0x12,0x34,0x56,0x0F in order; the last word's upper 4 bits are 0; the new pattern is resident afterwards.
- Backpressure: random s_valid gaps plus rb_ready held low for 5 cycles after the first rb_valid -> ccff_en=0 during stalls; rb_data stable; 28 enables total; readback and loaded contents bit-exact.
- start while busy pulsed mid-SHIFT, and start coincident with done -> no effect; the next start in IDLE begins a fresh load with bit_count=0.
- pReset asserted after 10 shifted bits -> next cycle busy=0, ccff_en=0, rb_valid=0, bit_count=0; a subsequent start loads all 28 bits and consumes 4 new words.
- CHAIN_LEN=16, DATA_W=8 -> exactly 2 words accepted, no third s_ready; done follows acceptance of the 2nd rb word.
